// File: rtl/capture_sequencer.sv
// Sniff capture sequencer: arm, wait for a pattern match, gate FIFO writes for a
// programmed number of events, and emit a delayed, width-controlled trigger pulse.
module capture_sequencer #(
    parameter int pTRIGGER_DELAY_WIDTH = 20,
    parameter int pTRIGGER_WIDTH_WIDTH = 16,
    parameter int pCAPTURE_LEN_WIDTH   = 16
) (
    input  logic                            fe_clk,
    input  logic                            reset_n,
    input  logic                            I_arm,
    input  logic                            I_match,
    input  logic [pCAPTURE_LEN_WIDTH-1:0]   I_capture_len,
    input  logic [pTRIGGER_DELAY_WIDTH-1:0] I_trigger_delay,
    input  logic [pTRIGGER_WIDTH_WIDTH-1:0] I_trigger_width,
    input  logic                            I_fe_capture_data_wr,
    input  logic                            I_fifo_full,
    output logic                            O_capturing,
    output logic                            O_trigger,
    output logic                            O_done,
    output logic                            O_overflow,
    output logic [pCAPTURE_LEN_WIDTH-1:0]   O_capture_count,
    output logic [2:0]                      O_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        DONE    = 3'd3
    } state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_DELAY = 2'd1,
        T_PULSE = 2'd2
    } tstate_t;

    localparam logic [pCAPTURE_LEN_WIDTH-1:0]   C_ONE     = 1;
    localparam logic [pCAPTURE_LEN_WIDTH-1:0]   COUNT_MAX = '1;
    localparam logic [pTRIGGER_DELAY_WIDTH-1:0] D_ONE     = 1;
    localparam logic [pTRIGGER_WIDTH_WIDTH-1:0] W_ONE     = 1;

    state_t                          state_reg, state_next;
    tstate_t                         tstate_reg, tstate_next;
    logic                            arm_prev_reg;
    logic                            capturing_reg, capturing_next;
    logic                            trigger_reg, trigger_next;
    logic                            done_reg, done_next;
    logic                            overflow_reg, overflow_next;
    logic [pCAPTURE_LEN_WIDTH-1:0]   count_reg, count_next;
    logic [pCAPTURE_LEN_WIDTH-1:0]   len_lat_reg, len_lat_next;
    logic [pTRIGGER_WIDTH_WIDTH-1:0] width_lat_reg, width_lat_next;
    logic [pTRIGGER_DELAY_WIDTH-1:0] delay_cnt_reg, delay_cnt_next;
    logic [pTRIGGER_WIDTH_WIDTH-1:0] width_cnt_reg, width_cnt_next;

    logic                            arm_rise;
    logic                            accept;
    logic [pCAPTURE_LEN_WIDTH-1:0]   count_inc;

    assign arm_rise  = I_arm & ~arm_prev_reg;
    assign accept    = I_fe_capture_data_wr & ~I_fifo_full;
    assign count_inc = count_reg + C_ONE;

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            tstate_reg    <= T_IDLE;
            arm_prev_reg  <= 1'b0;
            capturing_reg <= 1'b0;
            trigger_reg   <= 1'b0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            count_reg     <= '0;
            len_lat_reg   <= '0;
            width_lat_reg <= '0;
            delay_cnt_reg <= '0;
            width_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            tstate_reg    <= tstate_next;
            arm_prev_reg  <= I_arm;
            capturing_reg <= capturing_next;
            trigger_reg   <= trigger_next;
            done_reg      <= done_next;
            overflow_reg  <= overflow_next;
            count_reg     <= count_next;
            len_lat_reg   <= len_lat_next;
            width_lat_reg <= width_lat_next;
            delay_cnt_reg <= delay_cnt_next;
            width_cnt_reg <= width_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tstate_next    = tstate_reg;
        capturing_next = capturing_reg;
        trigger_next   = trigger_reg;
        done_next      = done_reg;
        overflow_next  = overflow_reg;
        count_next     = count_reg;
        len_lat_next   = len_lat_reg;
        width_lat_next = width_lat_reg;
        delay_cnt_next = delay_cnt_reg;
        width_cnt_next = width_cnt_reg;

        // Free-running trigger sequencing; the main FSM below may start or abort it.
        case (tstate_reg)
            T_DELAY: begin
                if (delay_cnt_reg == '0) begin
                    tstate_next    = T_PULSE;
                    trigger_next   = 1'b1;
                    width_cnt_next = (width_lat_reg == '0) ? '0 : width_lat_reg - W_ONE;
                end else begin
                    delay_cnt_next = delay_cnt_reg - D_ONE;
                end
            end
            T_PULSE: begin
                if (width_cnt_reg == '0) begin
                    tstate_next  = T_IDLE;
                    trigger_next = 1'b0;
                end else begin
                    width_cnt_next = width_cnt_reg - W_ONE;
                end
            end
            default: begin
                tstate_next  = T_IDLE;
                trigger_next = 1'b0;
            end
        endcase

        case (state_reg)
            IDLE: begin
                if (arm_rise) begin
                    state_next    = ARMED;
                    overflow_next = 1'b0;
                    count_next    = '0;
                    done_next     = 1'b0;
                end
            end
            ARMED: begin
                if (!I_arm) begin
                    state_next = IDLE;
                end else if (I_match) begin
                    state_next     = CAPTURE;
                    capturing_next = 1'b1;
                    len_lat_next   = I_capture_len;
                    width_lat_next = I_trigger_width;
                    if (I_trigger_delay == '0) begin
                        tstate_next    = T_PULSE;
                        trigger_next   = 1'b1;
                        width_cnt_next = (I_trigger_width == '0) ? '0 : I_trigger_width - W_ONE;
                    end else begin
                        tstate_next    = T_DELAY;
                        delay_cnt_next = I_trigger_delay - D_ONE;
                    end
                end
            end
            CAPTURE: begin
                if (!I_arm) begin
                    state_next     = IDLE;
                    capturing_next = 1'b0;
                    tstate_next    = T_IDLE;
                    trigger_next   = 1'b0;
                end else begin
                    if (I_fe_capture_data_wr && I_fifo_full) begin
                        overflow_next = 1'b1;
                    end
                    // Unlimited length saturates rather than wrapping.
                    if (accept && (count_reg != COUNT_MAX)) begin
                        count_next = count_inc;
                        if ((len_lat_reg != '0) && (count_inc == len_lat_reg)) begin
                            state_next     = DONE;
                            capturing_next = 1'b0;
                            done_next      = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (!I_arm) begin
                    state_next = IDLE;
                    done_next  = 1'b0;
                end
            end
            default: begin
                state_next     = IDLE;
                capturing_next = 1'b0;
                done_next      = 1'b0;
            end
        endcase
    end

    assign O_state         = state_reg;
    assign O_capturing     = capturing_reg;
    assign O_trigger       = trigger_reg;
    assign O_done          = done_reg;
    assign O_overflow      = overflow_reg;
    assign O_capture_count = count_reg;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed-vector bench for capture_sequencer: arm/capture/done flow, trigger timing,
// FIFO-full overflow, abort, unlimited capture saturation, latching and async reset.
module tb_capture_sequencer;

    logic        fe_clk = 1'b0;
    logic        reset_n;
    logic        I_arm;
    logic        I_match;
    logic [15:0] I_capture_len;
    logic [19:0] I_trigger_delay;
    logic [15:0] I_trigger_width;
    logic        I_fe_capture_data_wr;
    logic        I_fifo_full;
    logic        O_capturing;
    logic        O_trigger;
    logic        O_done;
    logic        O_overflow;
    logic [15:0] O_capture_count;
    logic [2:0]  O_state;

    int vectors = 0;
    int miscompares = 0;

    capture_sequencer dut (
        .fe_clk               (fe_clk),
        .reset_n              (reset_n),
        .I_arm                (I_arm),
        .I_match              (I_match),
        .I_capture_len        (I_capture_len),
        .I_trigger_delay      (I_trigger_delay),
        .I_trigger_width      (I_trigger_width),
        .I_fe_capture_data_wr (I_fe_capture_data_wr),
        .I_fifo_full          (I_fifo_full),
        .O_capturing          (O_capturing),
        .O_trigger            (O_trigger),
        .O_done               (O_done),
        .O_overflow           (O_overflow),
        .O_capture_count      (O_capture_count),
        .O_state              (O_state)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic do_arm();
        I_arm = 1'b1;
        tick();
        check("arm_state", 32'(O_state), 32'd1);
    endtask

    task automatic do_match(input logic [15:0] len, input logic [19:0] dly, input logic [15:0] wid);
        I_capture_len   = len;
        I_trigger_delay = dly;
        I_trigger_width = wid;
        I_match         = 1'b1;
        tick();
        I_match         = 1'b0;
    endtask

    task automatic do_disarm();
        I_arm = 1'b0;
        tick();
        check("disarm_state", 32'(O_state), 32'd0);
    endtask

    logic [31:0] mask;
    int          hi_cycles;
    logic        trig_seen;

    initial begin
        reset_n = 1'b0;
        I_arm = 1'b0; I_match = 1'b0;
        I_capture_len = '0; I_trigger_delay = '0; I_trigger_width = '0;
        I_fe_capture_data_wr = 1'b0; I_fifo_full = 1'b0;
        repeat (3) tick();
        check("rst_state", 32'(O_state), 32'd0);
        check("rst_capturing", 32'(O_capturing), 32'd0);
        check("rst_trigger", 32'(O_trigger), 32'd0);
        check("rst_done", 32'(O_done), 32'd0);
        check("rst_overflow", 32'(O_overflow), 32'd0);
        check("rst_count", 32'(O_capture_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic flow: len=4, delay=0, width=1
        do_arm();
        do_match(16'd4, 20'd0, 16'd1);
        check("t1_trig_t1", 32'(O_trigger), 32'd1);
        check("t1_capturing", 32'(O_capturing), 32'd1);
        check("t1_state_cap", 32'(O_state), 32'd2);
        I_fe_capture_data_wr = 1'b1;
        tick();
        check("t1_trig_t2", 32'(O_trigger), 32'd0);
        check("t1_count1", 32'(O_capture_count), 32'd1);
        repeat (3) tick();
        I_fe_capture_data_wr = 1'b0;
        check("t1_done", 32'(O_done), 32'd1);
        check("t1_count4", 32'(O_capture_count), 32'd4);
        check("t1_capturing_off", 32'(O_capturing), 32'd0);
        check("t1_state_done", 32'(O_state), 32'd3);
        repeat (3) tick();
        check("t1_hold_done", 32'(O_state), 32'd3);
        do_disarm();
        check("t1_done_cleared", 32'(O_done), 32'd0);
        check("t1_count_held", 32'(O_capture_count), 32'd4);

        // Trigger timing: delay=10, width=3 -> high at t+11..t+13
        do_arm();
        check("t2_count_cleared", 32'(O_capture_count), 32'd0);
        do_match(16'd4, 20'd10, 16'd3);
        mask = '0;
        for (int i = 1; i <= 20; i++) begin
            mask[i] = O_trigger;
            tick();
        end
        check("t2_trig_mask_w3", mask, 32'h0000_3800);
        do_disarm();

        // Width 0 behaves as width 1
        do_arm();
        do_match(16'd4, 20'd10, 16'd0);
        mask = '0;
        for (int i = 1; i <= 20; i++) begin
            mask[i] = O_trigger;
            tick();
        end
        check("t2_trig_mask_w0", mask, 32'h0000_0800);
        do_disarm();

        // FIFO full for 2 of 10 write cycles, len=8
        do_arm();
        do_match(16'd8, 20'd0, 16'd1);
        I_fe_capture_data_wr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            I_fifo_full = (i == 3 || i == 4);
            tick();
            if (i == 8) begin
                check("t3_count7", 32'(O_capture_count), 32'd7);
                check("t3_not_done", 32'(O_state), 32'd2);
            end
        end
        I_fe_capture_data_wr = 1'b0;
        I_fifo_full = 1'b0;
        check("t3_state_done", 32'(O_state), 32'd3);
        check("t3_count8", 32'(O_capture_count), 32'd8);
        check("t3_overflow", 32'(O_overflow), 32'd1);
        do_disarm();
        check("t3_overflow_held", 32'(O_overflow), 32'd1);

        // Abort mid-delay: delay=100, disarm sampled at t+20
        do_arm();
        check("t4_overflow_cleared", 32'(O_overflow), 32'd0);
        do_match(16'd4, 20'd100, 16'd2);
        trig_seen = 1'b0;
        for (int i = 1; i < 20; i++) begin
            trig_seen |= O_trigger;
            tick();
        end
        I_arm = 1'b0;
        tick();
        check("t4_state_idle", 32'(O_state), 32'd0);
        check("t4_done", 32'(O_done), 32'd0);
        for (int i = 0; i < 120; i++) begin
            trig_seen |= O_trigger;
            tick();
        end
        check("t4_no_trigger", 32'(trig_seen), 32'd0);

        // Unlimited capture saturates at 0xFFFF
        do_arm();
        do_match(16'd0, 20'd0, 16'd1);
        I_fe_capture_data_wr = 1'b1;
        repeat (70000) tick();
        I_fe_capture_data_wr = 1'b0;
        check("t5_count_sat", 32'(O_capture_count), 32'h0000_FFFF);
        check("t5_state_cap", 32'(O_state), 32'd2);
        check("t5_capturing", 32'(O_capturing), 32'd1);
        do_disarm();
        check("t5_capturing_off", 32'(O_capturing), 32'd0);

        // Latching, second match ignored, pulse completes in DONE
        do_arm();
        do_match(16'd4, 20'd5, 16'd2);
        hi_cycles = 0;
        I_capture_len = 16'd9;
        I_trigger_width = 16'd7;
        I_fe_capture_data_wr = 1'b1;
        hi_cycles += int'(O_trigger);
        tick();
        I_match = 1'b1;
        hi_cycles += int'(O_trigger);
        tick();
        I_match = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hi_cycles += int'(O_trigger);
            tick();
        end
        I_fe_capture_data_wr = 1'b0;
        check("t6_state_done", 32'(O_state), 32'd3);
        check("t6_count4", 32'(O_capture_count), 32'd4);
        for (int i = 0; i < 20; i++) begin
            hi_cycles += int'(O_trigger);
            tick();
        end
        check("t6_trig_cycles", 32'(hi_cycles), 32'd2);
        do_disarm();
        do_arm();
        check("t6_rearm_count", 32'(O_capture_count), 32'd0);

        // Async reset mid-capture
        do_match(16'd4, 20'd0, 16'd5);
        I_fe_capture_data_wr = 1'b1;
        I_fifo_full = 1'b1;
        tick();
        I_fifo_full = 1'b0;
        tick();
        check("t7_pre_count", 32'(O_capture_count), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t7_rst_state", 32'(O_state), 32'd0);
        check("t7_rst_capturing", 32'(O_capturing), 32'd0);
        check("t7_rst_trigger", 32'(O_trigger), 32'd0);
        check("t7_rst_count", 32'(O_capture_count), 32'd0);
        check("t7_rst_overflow", 32'(O_overflow), 32'd0);
        I_fe_capture_data_wr = 1'b0;
        I_arm = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Front-end capture controller in the fe_clk domain. Sequences one sniff capture: arm, wait for a pattern match, gate capture writes into the sniff FIFO for a programmed length, then report done.
- Generates the delayed, width-controlled trigger output from the same match event.
- Sits between the register block (arm and configuration, already synchronised to fe_clk) and the pattern matcher, front-end capture and trigger pin.

Parameters:
- pTRIGGER_DELAY_WIDTH, 20, width of the trigger delay count.
- pTRIGGER_WIDTH_WIDTH, 16, width of the trigger pulse width count.
- pCAPTURE_LEN_WIDTH, 16, width of the capture length and event counter.

Ports:
- fe_clk  in  1  front-end clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_arm  in  1  arm level, already synchronised to fe_clk.
- I_match  in  1  single-cycle pattern match pulse.
- I_capture_len  in  pCAPTURE_LEN_WIDTH  events to capture; 0 = unlimited.
- I_trigger_delay  in  pTRIGGER_DELAY_WIDTH  cycles from match to trigger.
- I_trigger_width  in  pTRIGGER_WIDTH_WIDTH  trigger high cycles; 0 treated as 1.
- I_fe_capture_data_wr  in  1  front end presents one capture event this cycle.
- I_fifo_full  in  1  sniff FIFO full (write side).
- O_capturing  out  1  capture window open; gates FIFO writes.
- O_trigger  out  1  trigger output, registered.
- O_done  out  1  capture complete; held until disarm.
- O_overflow  out  1  sticky: an event was dropped because the FIFO was full.
- O_capture_count  out  pCAPTURE_LEN_WIDTH  events accepted this capture.
- O_state  out  3  main FSM state, for status readback.

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0; FSM in IDLE; trigger sub-FSM in T_IDLE; all counters 0.

Main FSM, with encodings IDLE=0, ARMED=1, CAPTURE=2, DONE=3:
- IDLE: on a rising edge of I_arm (registered previous value 0, current 1), go to ARMED. In the same transition, clear O_overflow, O_capture_count and O_done. A level-high I_arm with no rising edge does not re-arm.
- ARMED: on I_match=1, go to CAPTURE. Latch I_capture_len, I_trigger_delay and I_trigger_width in that cycle; later changes to these inputs have no effect on the running capture. On I_arm=0, go to IDLE. I_match is ignored in every other state.
- CAPTURE:
  - O_capturing=1 starting the cycle after the match.
  - Each cycle with I_fe_capture_data_wr=1 and I_fifo_full=0 increments O_capture_count.
  - I_fe_capture_data_wr=1 with I_fifo_full=1 sets O_overflow and does not increment the count.
  - When the increment makes the count equal the latched length (length != 0), go to DONE the next cycle. That last event is counted, and O_capturing drops together with the entry into DONE.
  - Latched length 0: the count saturates at all-ones and does not wrap; exit only on disarm.
  - I_arm=0: go to IDLE, O_capturing=0 the next cycle, O_done stays 0.
- DONE: O_done=1, O_capturing=0. I_arm=0 returns the FSM to IDLE and clears O_done. O_capture_count and O_overflow hold until the next arm.
- Priority: disarm beats match in ARMED, and beats the final count in CAPTURE.

Trigger sub-FSM, with states T_IDLE, T_DELAY, T_PULSE:
- Started by the same match that enters CAPTURE.
- O_trigger rises exactly latched_delay+1 cycles after the I_match cycle. Delay 0 means O_trigger is high on the cycle after the match.
- O_trigger stays high for max(latched_width,1) cycles, then returns to T_IDLE.
- A pulse already in progress completes even if the main FSM reaches DONE.
- Disarm (main FSM leaving ARMED or CAPTURE for IDLE) forces T_IDLE and O_trigger=0 on the next cycle.
- Only one trigger per arm.
- Delay counter width is pTRIGGER_DELAY_WIDTH; all-ones is a legal delay and does not wrap early.

General:
- All outputs are registered; no combinational path from any input to any output.
- O_state reflects the current main FSM state with 0 latency.

Test Plan:
- Reset and arm: reset_n low then high, pulse I_arm 0->1, then I_match at cycle t. With len=4, delay=0, width=1: O_trigger is high at t+1 only, O_capturing is high from t+1, and after 4 data_wr cycles O_done=1 and O_capture_count=4.
- Trigger timing: delay=10, width=3, match at t. O_trigger is high exactly on cycles t+11..t+13. With width=0, only t+11.
- FIFO full: len=8, data_wr every cycle, I_fifo_full high for 2 of them. O_overflow=1, and DONE is reached only after 8 accepted events (10 wr cycles).
- Abort: disarm mid-delay (delay=100, I_arm low at t+20). O_trigger never asserts, FSM is in IDLE at t+21, and O_done stays 0.
- Unlimited capture: len=0, 70000 wr cycles. O_capture_count saturates at 0xFFFF, the FSM remains in CAPTURE, and disarm returns it to IDLE.
- Re-arm and latching: change I_capture_len from 4 to 9 mid-capture; DONE still occurs at 4. Holding I_arm high in DONE does not re-arm; dropping and raising I_arm clears count and overflow and enters ARMED. A second I_match in CAPTURE produces no second trigger. Asserting reset_n low mid-CAPTURE zeroes all outputs immediately.
